// File: rtl/display_scheduler_pkg.sv
// Shared definitions for the multiplexed 4-digit display scheduler:
// glyph codes, FSM state encoding and the anode one-hot-low table.
package disp_pkg;

    localparam logic [3:0] GLYPH_BLANK = 4'hF;

    typedef enum logic {
        ST_VAL = 1'b0,
        ST_MSG = 1'b1
    } state_e;

    // Nibble s holds the anode pattern for digit s (active-low, one-hot-low).
    localparam logic [15:0] AN_TABLE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    function automatic logic [3:0] an_for(input logic [1:0] s);
        return AN_TABLE[{s, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] nibble(input logic [15:0] w, input logic [1:0] i);
        return w[{i, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Bundle between the credit/price datapath, the status-message requester
// and the display scheduler, plus the scanned display drive.
interface display_scheduler_if;
    logic [15:0] val_bcd;
    logic        blank_lz;
    logic        msg_req;
    logic [15:0] msg_code;
    logic        msg_ack;
    logic        busy;
    logic [1:0]  S;
    logic [3:0]  AN;
    logic [3:0]  digit;

    modport master (
        output val_bcd, blank_lz, msg_req, msg_code,
        input  msg_ack, busy, S, AN, digit
    );

    modport slave (
        input  val_bcd, blank_lz, msg_req, msg_code,
        output msg_ack, busy, S, AN, digit
    );
endinterface

// File: rtl/display_scheduler_scan_prescaler.sv
// Digit-slot timer: wraps every REFRESH_DIV clocks, pulses scan_en on the last
// count and flags the anti-ghost blank window at the start of each slot.
module scan_prescaler #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 2
) (
    input  logic clk,
    input  logic clr,
    output logic scan_en,
    output logic blank
);
    localparam int              CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign scan_en = (cnt_q == CNT_LAST);
    assign blank   = (cnt_q < BLANK_LIM);

    always_comb begin
        cnt_d = scan_en ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/display_scheduler.sv
// Four-digit scan scheduler: shows a frame-shadowed BCD value with optional
// leading-zero blanking, or a latched status message for MSG_HOLD frames.
module display_scheduler
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 2,
    parameter int MSG_HOLD    = 250
) (
    input  logic              clk,
    input  logic              clr,
    display_scheduler_if.slave bus
);
    localparam logic [15:0] HOLD_INIT = 16'(MSG_HOLD);

    logic        scan_en;
    logic        blank_win;
    logic        frame_end;

    logic [1:0]  s_q, s_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] msg_q, msg_d;
    logic [15:0] hold_q, hold_d;
    state_e      state_q, state_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        blank_lz_q, blank_lz_d;

    logic [3:0]  nz;
    logic [3:0]  lead_zero;
    logic [15:0] digit_src;
    logic [3:0]  digit_mux;

    scan_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) u_prescaler (
        .clk     (clk),
        .clr     (clr),
        .scan_en (scan_en),
        .blank   (blank_win)
    );

    assign frame_end = scan_en && (s_q == 2'd3);

    // A request always wins, including on the expiry frame_end, so a fresh
    // message never flashes the value for a frame in between.
    always_comb begin
        s_d        = scan_en ? s_q + 1'b1 : s_q;
        shadow_d   = frame_end ? bus.val_bcd : shadow_q;
        blank_lz_d = bus.blank_lz;
        state_d    = state_q;
        hold_d     = hold_q;
        msg_d      = msg_q;
        ack_d      = 1'b0;
        if (bus.msg_req) begin
            msg_d   = bus.msg_code;
            ack_d   = 1'b1;
            hold_d  = HOLD_INIT;
            state_d = ST_MSG;
        end else if (state_q == ST_MSG && frame_end) begin
            hold_d = hold_q - 1'b1;
            if (hold_q == 16'd1) begin
                state_d = ST_VAL;
            end
        end
        busy_d = (state_d == ST_MSG);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s_q        <= 2'd0;
            shadow_q   <= 16'h0000;
            msg_q      <= 16'hFFFF;
            hold_q     <= 16'd0;
            state_q    <= ST_VAL;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            blank_lz_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            shadow_q   <= shadow_d;
            msg_q      <= msg_d;
            hold_q     <= hold_d;
            state_q    <= state_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            blank_lz_q <= blank_lz_d;
        end
    end

    // lead_zero[i]: every shadow digit at index i and above is zero.
    // Digit 0 is never blanked, so an all-zero value still shows "0".
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit_flags
        assign nz[gi] = |shadow_q[gi*4 +: 4];
        if (gi == 0) begin : g_first
            assign lead_zero[gi] = 1'b0;
        end else begin : g_upper
            assign lead_zero[gi] = ~|nz[3:gi];
        end
    end

    always_comb begin
        digit_src = (state_q == ST_MSG) ? msg_q : shadow_q;
        digit_mux = nibble(digit_src, s_q);
        if (state_q == ST_VAL && blank_lz_q && lead_zero[s_q]) begin
            digit_mux = GLYPH_BLANK;
        end
    end

    assign bus.S       = s_q;
    assign bus.AN      = blank_win ? 4'b1111 : an_for(s_q);
    assign bus.digit   = digit_mux;
    assign bus.msg_ack = ack_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with REFRESH_DIV=8, BLANK_CYC=1, MSG_HOLD=2.
module tb_display_scheduler;

    logic clk;
    logic clr;
    int   errors;
    int   checks;
    int   k;

    display_scheduler_if bus_if ();

    display_scheduler #(
        .REFRESH_DIV (8),
        .BLANK_CYC   (1),
        .MSG_HOLD    (2)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; k counts edges since reset release (count = k%8, S = (k/8)%4).
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic goto(input int pos);
        do tick(); while ((k % 32) != pos);
    endtask

    task automatic chk_slot(input string tag, input int s, input logic [3:0] e);
        goto(s * 8 + 4);
        check({tag, "_S"}, {14'd0, bus_if.S}, 16'(s));
        check(tag, {12'd0, bus_if.digit}, {12'd0, e});
    endtask

    task automatic frame_digits(input string tag, input logic [15:0] e);
        for (int s = 0; s < 4; s++) begin
            chk_slot(tag, s, e[s*4 +: 4]);
        end
    endtask

    task automatic send_msg(input logic [15:0] code);
        goto(31);
        bus_if.msg_req  = 1'b1;
        bus_if.msg_code = code;
        tick();
        check("ack_pulse", {15'd0, bus_if.msg_ack}, 16'd1);
        check("busy_set", {15'd0, bus_if.busy}, 16'd1);
        bus_if.msg_req = 1'b0;
        tick();
        check("ack_single", {15'd0, bus_if.msg_ack}, 16'd0);
    endtask

    function automatic logic [3:0] exp_an(input int kk);
        logic [3:0] tbl [4];
        tbl[0] = 4'b1110;
        tbl[1] = 4'b1101;
        tbl[2] = 4'b1011;
        tbl[3] = 4'b0111;
        if ((kk % 8) == 0) return 4'b1111;
        return tbl[(kk / 8) % 4];
    endfunction

    initial begin
        errors          = 0;
        checks          = 0;
        k               = 0;
        clr             = 1'b1;
        bus_if.val_bcd  = 16'h0000;
        bus_if.blank_lz = 1'b0;
        bus_if.msg_req  = 1'b0;
        bus_if.msg_code = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_AN", {12'd0, bus_if.AN}, 16'h000F);
        check("rst_S", {14'd0, bus_if.S}, 16'd0);
        check("rst_busy", {15'd0, bus_if.busy}, 16'd0);
        check("rst_ack", {15'd0, bus_if.msg_ack}, 16'd0);
        check("rst_digit", {12'd0, bus_if.digit}, 16'd0);
        clr = 1'b0;
        k   = 0;

        // Scan: S and AN across five digit slots
        check("scan_S", {14'd0, bus_if.S}, 16'd0);
        check("scan_AN", {12'd0, bus_if.AN}, {12'd0, exp_an(k)});
        for (int i = 0; i < 40; i++) begin
            tick();
            check("scan_S", {14'd0, bus_if.S}, 16'((k / 8) % 4));
            check("scan_AN", {12'd0, bus_if.AN}, {12'd0, exp_an(k)});
        end

        // Leading-zero blanking
        goto(28);
        bus_if.val_bcd  = 16'h0052;
        bus_if.blank_lz = 1'b1;
        frame_digits("lz_0052", 16'hFF52);
        bus_if.val_bcd = 16'h0000;
        frame_digits("lz_zero", 16'hFFF0);
        bus_if.val_bcd  = 16'h0052;
        bus_if.blank_lz = 1'b0;
        frame_digits("nolz_0052", 16'h0052);

        // Single message: exactly two frames, then back to the value
        send_msg(16'hABCD);
        frame_digits("msg_f1", 16'hABCD);
        frame_digits("msg_f2", 16'hABCD);
        check("msg_busy_last", {15'd0, bus_if.busy}, 16'd1);
        frame_digits("msg_back_val", 16'h0052);
        check("msg_busy_clr", {15'd0, bus_if.busy}, 16'd0);

        // Collision: new request on the expiry frame_end
        send_msg(16'hABCD);
        frame_digits("col_a1", 16'hABCD);
        frame_digits("col_a2", 16'hABCD);
        send_msg(16'h1234);
        frame_digits("col_b1", 16'h1234);
        check("col_busy_mid", {15'd0, bus_if.busy}, 16'd1);
        frame_digits("col_b2", 16'h1234);
        frame_digits("col_val", 16'h0052);
        check("col_busy_clr", {15'd0, bus_if.busy}, 16'd0);

        // Tearing: value change mid-frame waits for the next frame
        bus_if.val_bcd = 16'h1111;
        frame_digits("tear_1", 16'h1111);
        chk_slot("tear_cur", 0, 4'h1);
        chk_slot("tear_cur", 1, 4'h1);
        goto(16);
        bus_if.val_bcd = 16'h2222;
        chk_slot("tear_cur", 2, 4'h1);
        chk_slot("tear_cur", 3, 4'h1);
        frame_digits("tear_2", 16'h2222);

        // Reset in the middle of a message
        send_msg(16'h5678);
        frame_digits("rmsg_f1", 16'h5678);
        goto(12);
        clr = 1'b1;
        #1;
        check("rmsg_AN", {12'd0, bus_if.AN}, 16'h000F);
        check("rmsg_busy", {15'd0, bus_if.busy}, 16'd0);
        check("rmsg_ack", {15'd0, bus_if.msg_ack}, 16'd0);
        check("rmsg_S", {14'd0, bus_if.S}, 16'd0);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        k   = 0;
        check("post_S", {14'd0, bus_if.S}, 16'd0);
        check("post_busy", {15'd0, bus_if.busy}, 16'd0);
        check("post_digit", {12'd0, bus_if.digit}, 16'd0);
        repeat (4) tick();
        check("post_AN", {12'd0, bus_if.AN}, 16'h000E);
        check("post_digit4", {12'd0, bus_if.digit}, 16'd0);
        check("post_ack", {15'd0, bus_if.msg_ack}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter REFRESH_DIV, 100000, clk cycles per digit slot; legal range 4 or more.
REQ-002 Parameter BLANK_CYC, 2, anti-ghost blank cycles at the start of each slot; legal range 1 to REFRESH_DIV-1.
REQ-003 Parameter MSG_HOLD, 250, message display time in full scan frames; legal range 1 to 65535.
REQ-004 clk  in  1  system clock; only clock in the block.
REQ-005 clr  in  1  reset, asynchronous, active-high.
REQ-006 val_bcd  in  16  four BCD digits from the credit/price datapath; [3:0] is digit 0 (rightmost).
REQ-007 blank_lz  in  1  enables leading-zero blanking of the value.
REQ-008 msg_req  in  1  status-message request; level, sampled every clk.
REQ-009 msg_code  in  16  four 4-bit glyph codes; sampled when msg_req is accepted.
REQ-010 msg_ack  out  1  one-cycle pulse when a message is accepted.
REQ-011 busy  out  1  high while in state MSG.
REQ-012 S  out  2  current digit index.
REQ-013 AN  out  4  anode enables, active-low, one-hot-low.
REQ-014 digit  out  4  glyph code for the segment decoder.

Function
REQ-015 The prescaler SHALL count 0 to REFRESH_DIV-1 and wrap; scan_en SHALL pulse on the cycle the count equals REFRESH_DIV-1.
REQ-016 S SHALL increment on each scan_en and wrap from 3 to 0; frame_end is scan_en while S==3.
REQ-017 AN SHALL be: S=0 gives 1110, S=1 gives 1101, S=2 gives 1011, S=3 gives 0111.
REQ-018 AN SHALL be forced to 1111 while the prescaler count is less than BLANK_CYC.
REQ-019 On frame_end, val_bcd SHALL be copied into a shadow register; the VAL display SHALL use only the shadow, so no frame tears.
REQ-020 The FSM SHALL have two states: VAL (show shadow) and MSG (show latched msg_code).
REQ-021 In VAL with msg_req=1: latch msg_code, pulse msg_ack, load hold=MSG_HOLD, go to MSG on the next cycle.
REQ-022 In MSG, hold SHALL decrement on each frame_end; when hold reaches 0, return to VAL.
REQ-023 In MSG with msg_req=1, the new message SHALL preempt: relatch, ack, reload hold; latest request wins.
REQ-024 msg_req on the same cycle as expiry SHALL take priority: stay in MSG with a reload, no pass through VAL.
REQ-025 msg_ack SHALL pulse on every accepted cycle; a requester holding msg_req high gets repeated acks, so it SHALL drop msg_req after the ack.
REQ-026 digit SHALL be the nibble at index S of the shadow (VAL) or of the message latch (MSG).
REQ-027 With blank_lz=1 in VAL, digit SHALL be GLYPH_BLANK (4'hF) for each index above the highest nonzero digit; digit 0 is never blanked; an all-zero value shows a single 0.
REQ-028 AN and digit SHALL be combinational from registers only, with no input-to-output combinational path.
REQ-029 The state change SHALL take effect on the digit output in the cycle after acceptance; S and the prescaler SHALL be unaffected by state changes.

Reset
REQ-030 While clr=1, asynchronously: prescaler=0, S=0, state=VAL, hold=0, shadow=0, message latch=FFFF, msg_ack=0, busy=0, AN=1111.
REQ-031 clr asserted mid-message SHALL abort the message with no ack; after release, the display restarts at digit 0 in VAL.

Structure
REQ-032 Shared package disp_pkg SHALL hold: GLYPH_BLANK, FSM state encoding (ST_VAL, ST_MSG), and the AN one-hot-low table.
REQ-033 One sub-module, scan_prescaler, SHALL contain the REFRESH_DIV counter and the scan_en and blank window outputs; the FSM, shadow and mux SHALL stay in display_scheduler.
REQ-034 Target size is 120 to 400 lines of RTL in total.

Verification (bench parameters: REFRESH_DIV=8, BLANK_CYC=1, MSG_HOLD=2)
REQ-035 Scan: release clr, idle -> S steps 0,1,2,3,0 every 8 clk; AN=1111 on count 0, then 1110, 1101, 1011, 0111 for counts 1 to 7.
REQ-036 Blanking: val_bcd=16'h0052, blank_lz=1 -> digit F,F,5,2 for S=3..0; all-zero value -> F,F,F,0; blank_lz=0 -> 0,0,5,2.
REQ-037 Message: msg_req pulse with msg_code=16'hABCD -> one msg_ack, busy=1, digits D,C,B,A for S=0..3 for exactly 2 frames, then VAL.
REQ-038 Preempt and collision: second msg_req (16'h1234) at the expiry frame_end -> ack, stays MSG, shows 1234 for 2 more frames.
REQ-039 Tearing: change val_bcd from 1111 to 2222 at S=2 -> current frame stays all 1; the next frame is all 2.
REQ-040 Reset mid-MSG: clr during hold=1 -> AN=1111, busy=0 immediately; after release, VAL shows the zero value at S=0.
